// File: rtl/gpu_pkg.sv
// Shared GPU core types: the per-core state broadcast to
// register files, ALUs and LSUs.
package gpu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        REQUEST = 3'd3,
        WAIT    = 3'd4,
        EXECUTE = 3'd5,
        UPDATE  = 3'd6,
        DONE    = 3'd7
    } core_state_t;

endpackage

// File: rtl/core_scheduler.sv
// Per-core control FSM: walks one thread block through the
// instruction cycle, owns the shared PC, flags lane divergence.
module core_scheduler
    import gpu_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_WIDTH          = 8,
    parameter int CNT_WIDTH         = 16,
    localparam int TC_W = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [TC_W-1:0]                       thread_count,
    input  logic                                  fetch_valid,
    input  logic                                  decoded_ret,
    input  logic [THREADS_PER_BLOCK-1:0]          lsu_busy,
    input  logic [THREADS_PER_BLOCK*PC_WIDTH-1:0] next_pc,
    output core_state_t                           core_state,
    output logic                                  fetch_req,
    output logic [PC_WIDTH-1:0]                   current_pc,
    output logic [THREADS_PER_BLOCK-1:0]          thread_enable,
    output logic                                  done,
    output logic                                  diverge_err,
    output logic [CNT_WIDTH-1:0]                  retired
);

    localparam int TPB = THREADS_PER_BLOCK;

    core_state_t          r_state;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [TPB-1:0]       r_en;
    logic                 r_done;
    logic                 r_div;
    logic [CNT_WIDTH-1:0] r_ret;

    logic [TPB-1:0]       w_en_next;
    logic [PC_WIDTH-1:0]  w_lead_pc;
    logic                 w_diverge;
    logic                 w_stall;
    logic [CNT_WIDTH-1:0] w_ret_inc;

    always_comb begin
        w_en_next = '0;
        for (int i = 0; i < TPB; i++) begin
            w_en_next[i] = (thread_count > TC_W'(i));
        end
    end

    // Lowest enabled lane supplies the PC; any other enabled
    // lane that disagrees marks the block as diverged.
    always_comb begin
        w_lead_pc = '0;
        w_diverge = 1'b0;
        for (int i = TPB - 1; i >= 0; i--) begin
            if (r_en[i]) begin
                w_lead_pc = next_pc[i*PC_WIDTH +: PC_WIDTH];
            end
        end
        for (int i = 0; i < TPB; i++) begin
            if (r_en[i] &&
                (next_pc[i*PC_WIDTH +: PC_WIDTH] != w_lead_pc)) begin
                w_diverge = 1'b1;
            end
        end
    end

    assign w_stall   = |(lsu_busy & r_en);
    assign w_ret_inc = (&r_ret) ? r_ret : r_ret + CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_en    <= '0;
            r_done  <= 1'b0;
            r_div   <= 1'b0;
            r_ret   <= '0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_en  <= w_en_next;
                        r_pc  <= '0;
                        r_ret <= '0;
                        r_div <= 1'b0;
                        if (thread_count == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= FETCH;
                            r_done  <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    if (fetch_valid) r_state <= DECODE;
                end
                DECODE:  r_state <= REQUEST;
                REQUEST: r_state <= WAIT;
                WAIT: begin
                    if (!w_stall) r_state <= EXECUTE;
                end
                EXECUTE: r_state <= UPDATE;
                UPDATE: begin
                    r_ret <= w_ret_inc;
                    if (decoded_ret) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_pc    <= w_lead_pc;
                        r_state <= FETCH;
                        if (w_diverge) r_div <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign core_state    = r_state;
    assign fetch_req     = (r_state == FETCH);
    assign current_pc    = r_pc;
    assign thread_enable = r_en;
    assign done          = r_done;
    assign diverge_err   = r_div;
    assign retired       = r_ret;

endmodule

// File: tb/tb_core_scheduler.sv
// Bench for core_scheduler: start vectors, directed
// corner sequences and random traffic against a lane model.
module tb_core_scheduler;
    import gpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, fetch_valid, decoded_ret;
    logic [2:0]  thread_count;
    logic [3:0]  lsu_busy;
    logic [31:0] next_pc;
    core_state_t core_state;
    logic        fetch_req, done, diverge_err;
    logic [7:0]  current_pc;
    logic [3:0]  thread_enable;
    logic [15:0] retired;

    core_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .thread_count (thread_count),
        .fetch_valid  (fetch_valid),
        .decoded_ret  (decoded_ret),
        .lsu_busy     (lsu_busy),
        .next_pc      (next_pc),
        .core_state   (core_state),
        .fetch_req    (fetch_req),
        .current_pc   (current_pc),
        .thread_enable(thread_enable),
        .done         (done),
        .diverge_err  (diverge_err),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference: block described as active-lane count, PC,
    // sticky flag and a plain integer retire count.
    core_state_t m_state;
    int          m_n;
    logic [7:0]  m_pc;
    logic        m_done, m_div;
    int          m_ret;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, a, e);
    endtask

    function automatic logic [3:0] m_mask();
        return 4'((1 << m_n) - 1);
    endfunction

    task automatic model_step();
        logic [7:0] lane [4];
        if (rst) begin
            m_state = IDLE; m_n = 0; m_pc = 0;
            m_done = 0; m_div = 0; m_ret = 0;
        end else if (m_state == IDLE || m_state == DONE) begin
            if (start) begin
                m_n    = (thread_count > 4) ? 4 : int'(thread_count);
                m_pc   = 0; m_ret = 0; m_div = 0;
                m_done = (m_n == 0);
                m_state = m_done ? DONE : FETCH;
            end
        end else if (m_state == FETCH) begin
            if (fetch_valid) m_state = DECODE;
        end else if (m_state == WAIT) begin
            if ((lsu_busy & m_mask()) == 0) m_state = EXECUTE;
        end else if (m_state == UPDATE) begin
            m_ret = (m_ret < 65535) ? m_ret + 1 : 65535;
            if (decoded_ret) begin
                m_state = DONE; m_done = 1;
            end else begin
                for (int i = 0; i < 4; i++) lane[i] = next_pc[8*i +: 8];
                for (int i = 1; i < m_n; i++)
                    if (lane[i] != lane[0]) m_div = 1;
                m_pc = lane[0];
                m_state = FETCH;
            end
        end else if (m_state == DECODE) m_state = REQUEST;
        else if (m_state == REQUEST) m_state = WAIT;
        else if (m_state == EXECUTE) m_state = UPDATE;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("state", 32'(core_state), 32'(m_state));
        chk("fetch_req", 32'(fetch_req), 32'(m_state == FETCH));
        chk("pc", 32'(current_pc), 32'(m_pc));
        chk("enable", 32'(thread_enable), 32'(m_mask()));
        chk("done", 32'(done), 32'(m_done));
        chk("diverge", 32'(diverge_err), 32'(m_div));
        chk("retired", 32'(retired), m_ret);
    endtask

    task automatic run_to(input core_state_t s, input string nm);
        for (int k = 0; k < 40; k++) begin
            if (core_state == s) break;
            tick();
        end
        chk(nm, 32'(core_state), 32'(s));
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic launch(input logic [2:0] tc);
        start = 1; thread_count = tc; tick(); start = 0;
    endtask

    task automatic wait_len(input logic [3:0] b, input int hold,
                            output int len);
        len = 0;
        for (int k = 0; k < 40; k++) begin
            if (core_state == REQUEST) break;
            tick();
        end
        lsu_busy = b;
        for (int k = 0; k < 40; k++) begin
            if (k == hold) lsu_busy = 4'h0;
            tick();
            if (core_state == WAIT) len++;
            else if (len > 0) break;
        end
        lsu_busy = 4'h0;
    endtask

    typedef struct {
        logic [2:0]  tc;
        logic [3:0]  en;
        core_state_t st;
        logic        dn;
    } vec_t;

    vec_t vt[6];
    int   len;
    bit   seen;

    initial begin
        vt[0] = '{3'd0, 4'b0000, DONE,  1'b1};
        vt[1] = '{3'd1, 4'b0001, FETCH, 1'b0};
        vt[2] = '{3'd2, 4'b0011, FETCH, 1'b0};
        vt[3] = '{3'd3, 4'b0111, FETCH, 1'b0};
        vt[4] = '{3'd4, 4'b1111, FETCH, 1'b0};
        vt[5] = '{3'd7, 4'b1111, FETCH, 1'b0};

        rst = 1; start = 0; thread_count = 3'd4; fetch_valid = 0;
        decoded_ret = 0; lsu_busy = 0; next_pc = 0;
        tick(); tick();
        rst = 0;
        chk("rst_state", 32'(core_state), 32'(IDLE));
        chk("rst_en", 32'(thread_enable), 0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            launch(vt[v].tc);
            chk("vec_en", 32'(thread_enable), 32'(vt[v].en));
            chk("vec_state", 32'(core_state), 32'(vt[v].st));
            chk("vec_done", 32'(done), 32'(vt[v].dn));
        end

        // rst mid-WAIT with every lane busy
        do_reset();
        fetch_valid = 1; lsu_busy = 4'hF; next_pc = 32'h09090909;
        launch(3'd4);
        run_to(WAIT, "t1_reach_wait");
        rst = 1; tick(); rst = 0; lsu_busy = 0;
        chk("t1_state", 32'(core_state), 32'(IDLE));
        chk("t1_done", 32'(done), 0);
        chk("t1_pc", 32'(current_pc), 0);
        chk("t1_ret", 32'(retired), 0);

        // six-cycle instruction latency
        next_pc = 32'h01010101;
        launch(3'd4);
        for (int k = 0; k < 6; k++) tick();
        chk("t2_state", 32'(core_state), 32'(FETCH));
        chk("t2_pc", 32'(current_pc), 32'h01);
        chk("t2_ret", 32'(retired), 1);

        // busy only on disabled lane, then a 3-cycle stall
        do_reset();
        launch(3'd2);
        wait_len(4'b0100, 100, len);
        chk("t3_wait_ignored", len, 1);
        wait_len(4'b0001, 3, len);
        chk("t3_wait_stall", len, 3);

        // divergence: lanes {3,3,7,3}
        do_reset();
        next_pc = {8'd3, 8'd7, 8'd3, 8'd3};
        launch(3'd4);
        run_to(UPDATE, "t4_upd1"); tick();
        chk("t4_pc", 32'(current_pc), 3);
        chk("t4_div", 32'(diverge_err), 1);
        next_pc = 32'h05050505;
        run_to(UPDATE, "t4_upd2"); tick();
        chk("t4_pc2", 32'(current_pc), 5);
        chk("t4_div_sticky", 32'(diverge_err), 1);
        decoded_ret = 1;
        run_to(UPDATE, "t4_upd3"); tick();
        decoded_ret = 0;
        launch(3'd4);
        chk("t4_div_clr", 32'(diverge_err), 0);

        // RET after three instructions, then relaunch
        do_reset();
        next_pc = 32'h02020202;
        launch(3'd4);
        for (int j = 0; j < 3; j++) begin
            run_to(UPDATE, "t5_upd");
            decoded_ret = (j == 2);
            tick();
            decoded_ret = 0;
        end
        chk("t5_state", 32'(core_state), 32'(DONE));
        chk("t5_done", 32'(done), 1);
        chk("t5_ret", 32'(retired), 3);
        launch(3'd3);
        chk("t5_restart", 32'(core_state), 32'(FETCH));
        chk("t5_done_clr", 32'(done), 0);
        chk("t5_pc_clr", 32'(current_pc), 0);

        // empty block never fetches
        do_reset();
        launch(3'd0);
        chk("t6_state", 32'(core_state), 32'(DONE));
        chk("t6_done", 32'(done), 1);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (fetch_req) seen = 1;
        end
        chk("t6_nofetch", 32'(seen), 0);

        // random traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 199) == 0);
            start        = ($urandom_range(0, 19) == 0);
            thread_count = 3'($urandom_range(0, 7));
            fetch_valid  = ($urandom_range(0, 1) == 1);
            decoded_ret  = ($urandom_range(0, 3) == 0);
            lsu_busy     = 4'($urandom);
            if ($urandom_range(0, 9) < 7)
                next_pc = {4{8'($urandom)}};
            else
                next_pc = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
